// File: rtl/addbit_bist.sv
// addbit_bist -- clocked built-in self-test engine for the 1-bit full adder
// `addbit`. It walks {a,b,ci} through all eight input combinations, waits a
// programmable settle time, samples {co,sum}, checks them against the
// full-adder truth table, counts mismatches and reports pass/fail.
//
// Parameters:
//   SETTLE  cycles between driving a vector and sampling the adder (1..15)
//   PASSES  full 8-vector sweeps per run (1..255)
//   ERR_W   width of the saturating error counter
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               run request, honoured only while busy=0
//   busy, done          run in progress / one-cycle end-of-run pulse
//   pass                err_cnt==0 at end of run, held until next start
//   a, b, ci            registered stimulus to the adder ({a,b,ci}=vec_idx)
//   sum, co             adder response
//   err_cnt             saturating mismatch count
//   vec_idx             current vector index
//   fail_valid/vec/obs  first-failure capture
//
// Build option: define ADDBIT_BIST_FAIL_CAPTURE_EN to build the first-failure
// capture registers; without it the fail_* ports are tied to 0.

module addbit_bist #(
  parameter int SETTLE = 2,
  parameter int PASSES = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             a,
  output logic             b,
  output logic             ci,
  input  logic             sum,
  input  logic             co,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       vec_idx,
  output logic             fail_valid,
  output logic [2:0]       fail_vec,
  output logic [1:0]       fail_obs
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(SETTLE - 1);
  localparam logic [7:0] PASS_LAST = 8'(PASSES);

  state_t           state, state_nxt;
  logic [3:0]       wait_cnt;
  logic [7:0]       sweep;
  logic [1:0]       smp;        // {co,sum} registered at the sample edge
  logic             accept;
  logic             exp_sum, exp_co;
  logic             mismatch;
  logic             last_vec;
  logic             run_end;
  logic [7:0]       sweep_inc;
  logic [ERR_W-1:0] err_nxt;

  // The stimulus is the vector register itself, so it is glitch-free and
  // has no path from sum/co.
  assign {a, b, ci} = vec_idx;

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = (state == ST_IDLE) && start;
    exp_sum   = a ^ b ^ ci;
    exp_co    = (a & b) | (a & ci) | (b & ci);
    // The response was sampled on the edge that entered CHECK and the
    // driven vector is still held, so the comparison is fully registered.
    mismatch  = (state == ST_CHECK) && (smp != {exp_co, exp_sum});
    last_vec  = (vec_idx == 3'd7);
    sweep_inc = sweep + 8'd1;
    run_end   = last_vec && (sweep_inc == PASS_LAST);
    err_nxt   = err_cnt;
    if (mismatch && (err_cnt != {ERR_W{1'b1}}))
      err_nxt = err_cnt + 1'b1;

    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_SETTLE;
      ST_SETTLE: if (wait_cnt == 4'd0) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = run_end ? ST_IDLE : ST_SETTLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every register here, including the internal sample, wait and sweep
  // registers, is reset so a mid-run reset leaves no stale run context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      vec_idx  <= 3'd0;
      wait_cnt <= 4'd0;
      sweep    <= 8'd0;
      smp      <= 2'b00;
    end else begin
      done <= 1'b0;
      smp  <= {co, sum};
      case (state)
        ST_IDLE: begin
          if (accept) begin
            busy     <= 1'b1;
            pass     <= 1'b0;
            err_cnt  <= '0;
            vec_idx  <= 3'd0;
            sweep    <= 8'd0;
            wait_cnt <= WAIT_LOAD;
          end
        end
        ST_SETTLE: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        end
        ST_CHECK: begin
          err_cnt <= err_nxt;
          if (run_end) begin
            vec_idx <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_nxt == '0);
          end else begin
            vec_idx  <= vec_idx + 3'd1;
            wait_cnt <= WAIT_LOAD;
            if (last_vec) sweep <= sweep_inc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADDBIT_BIST_FAIL_CAPTURE_EN
  // Only the first mismatch of a run is kept; later ones leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid <= 1'b0;
      fail_vec   <= 3'd0;
      fail_obs   <= 2'b00;
    end else if (accept) begin
      fail_valid <= 1'b0;
      fail_vec   <= 3'd0;
      fail_obs   <= 2'b00;
    end else if (mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_vec   <= vec_idx;
      fail_obs   <= smp;
    end
  end
`else
  assign fail_valid = 1'b0;
  assign fail_vec   = 3'd0;
  assign fail_obs   = 2'b00;
`endif

endmodule
